// File: rtl/yarp_fetch_unit.sv
// yarp_fetch_unit: PC generation and instruction fetch for the yarp RV32I core.
//
// The unit keeps one instruction-memory request in flight at a time. A fetched
// word goes to decode, tagged with its PC, over a valid/ready handshake. A
// redirect (taken branch or jal/jalr) moves the PC to a word-aligned target and
// squashes any wrong-path fetch that is still in flight.
//
// Ports:
//   clk, reset_n        core clock; synchronous active-low reset
//   redirect_i          redirect request from execute
//   redirect_pc_i       redirect target (bits [1:0] are dropped)
//   imem_req_valid_o    fetch request valid
//   imem_req_addr_o     fetch address (word aligned)
//   imem_req_ready_i    instruction memory accepts the request
//   imem_rsp_valid_i    response valid
//   imem_rsp_data_i     response instruction word
//   instr_valid_o       instruction available to decode
//   instr_o             instruction word
//   instr_pc_o          PC of instr_o
//   instr_ready_i       decode accepts the instruction
//   misalign_o          one-cycle pulse: the last redirect target was not word aligned
module yarp_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        capture;
    logic [31:0] redirect_target;

    assign redirect_target = {redirect_pc_i[31:2], 2'b00};

    // NOTE: every signal written in this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        capture = 1'b0;

        case (state_q)
            S_REQ: begin
                if (redirect_i) begin
                    pc_d = redirect_target;
                    // The old address is already accepted: its response must be dropped.
                    if (imem_req_ready_i) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (imem_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_i) begin
                    pc_d = redirect_target;
                    if (imem_rsp_valid_i) begin
                        // The response arriving now is wrong-path and is consumed here.
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rsp_valid_i) begin
                    if (kill_q) begin
                        // pc already holds the redirect target.
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        capture = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_i) begin
                    pc_d    = redirect_target;
                    state_d = S_REQ;
                end else if (instr_ready_i) begin
                    state_d = S_REQ;
                end
            end

            default: state_d = S_REQ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            instr_o    <= 32'h0;
            instr_pc_o <= 32'h0;
            misalign_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            misalign_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
            if (capture) begin
                instr_o    <= imem_rsp_data_i;
                instr_pc_o <= pc_q;
            end
        end
    end

    // The request is gated by reset_n so memory never sees a request during reset.
    assign imem_req_valid_o = reset_n && (state_q == S_REQ);
    assign imem_req_addr_o  = pc_q;
    assign instr_valid_o    = (state_q == S_HOLD);

endmodule

// File: doc/yarp_fetch_unit.md
Name: yarp_fetch_unit

Overview:
- PC-generation and instruction-fetch stage of the yarp RV32I core.
- Consumes the branch outcome, plus jump redirects, as a single redirect request with a target address.
- Issues one outstanding request at a time to instruction memory.
- Hands fetched instructions, each tagged with its PC, to decode over a valid/ready handshake.
- Squashes wrong-path fetches on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- redirect_i  input  1  redirect request: branch_taken OR jal/jalr from execute.
- redirect_pc_i  input  32  redirect target address.
- imem_req_valid_o  output  1  fetch request valid.
- imem_req_addr_o  output  32  fetch address, word aligned.
- imem_req_ready_i  input  1  instruction memory accepts the request.
- imem_rsp_valid_i  input  1  response data valid.
- imem_rsp_data_i  input  32  fetched instruction word.
- instr_valid_o  output  1  instruction available to decode.
- instr_o  output  32  instruction word.
- instr_pc_o  output  32  PC of instr_o.
- instr_ready_i  input  1  decode accepts instruction.
- misalign_o  output  1  one-cycle pulse: redirect target had bits [1:0] != 0.

Behaviour:
- Internal state: pc register (32b), kill flag, FSM with states REQ, WAIT, HOLD.
- Reset (reset_n=0 at a clock edge): pc=RESET_PC, state=REQ, kill=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, misalign_o=0. imem_req_valid_o is 0 while reset_n=0.
- REQ:
  - imem_req_valid_o=1, imem_req_addr_o=pc.
  - On imem_req_ready_i=1: go to WAIT.
  - Address may change while the request is not yet accepted; the imem port permits this.
- WAIT:
  - imem_req_valid_o=0.
  - On imem_rsp_valid_i=1 with kill=0: capture instr_o=imem_rsp_data_i and instr_pc_o=pc; set pc=pc+4; go to HOLD.
  - On imem_rsp_valid_i=1 with kill=1: drop the data; clear kill; go to REQ. pc is already the redirect target.
- HOLD:
  - instr_valid_o=1; instr_o and instr_pc_o held stable.
  - On instr_ready_i=1: go to REQ next cycle; instr_valid_o=0 from that cycle.
- Latency and throughput:
  - Address accepted in cycle N, response in N+1: instr_valid_o rises at N+2.
  - Minimum of 3 cycles per instruction; no prefetch.
- Redirect (redirect_i=1) has priority over every other event in the same cycle. Target is {redirect_pc_i[31:2],2'b00}; misalign_o=1 in the following cycle if redirect_pc_i[1:0]!=0.
  - REQ, ready=0: pc=target, stay in REQ; the next request carries the target.
  - REQ, ready=1: the old address is accepted; pc=target, kill=1, go to WAIT.
  - WAIT, no response: pc=target, kill=1.
  - WAIT, response in the same cycle: drop the data, pc=target, go to REQ, kill stays 0.
  - HOLD: pc=target, instr_valid_o=0 next cycle, go to REQ. If instr_ready_i=1 in the same cycle, the handshake completes and decode is responsible for squashing that instruction.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- imem_rsp_valid_i outside WAIT is ignored (no state change). This covers stale responses after reset.
- redirect_i during reset: ignored.
- Reset mid-operation: immediate return to reset values; any outstanding response is ignored.

Test Plan:
- Reset release, RESET_PC=0, memory always ready with 1-cycle response -> addresses 0x0, 0x4, 0x8 in order. First instr_valid_o is 3 cycles after reset release, with instr_pc_o=0x0.
- redirect_i=1 with redirect_pc_i=0x100 while in WAIT for address 0x8 -> response for 0x8 dropped, next request addr=0x100, then instr_pc_o=0x100.
- redirect_i=1 with redirect_pc_i=0x200 while in HOLD with instr_ready_i=0 (instr_pc_o=0x4) -> instr_valid_o falls next cycle, next request addr=0x200.
- imem_req_ready_i held 0 for 5 cycles -> imem_req_valid_o stays 1 with addr stable (0x0). Redirect to 0x40 on cycle 3 -> addr becomes 0x40, and only 0x40 is later accepted.
- redirect_pc_i=0x102 -> misalign_o pulses for exactly 1 cycle; next fetch addr=0x100.
- RESET_PC=32'hFFFF_FFFC, run 2 fetches -> addresses 0xFFFF_FFFC then 0x0000_0000. Separately, assert reset_n=0 while in WAIT, then inject rsp_valid after release -> the response is ignored and fetch restarts at RESET_PC.
